// File: rtl/vga_timing_pkg.sv
`default_nettype none
// ============================================================================
// Module   : vga_timing_pkg
// Purpose  : 640x480@60 VGA timing constants, colour width and the blank
//            colour, plus a small window-decode helper.
// Revision : 1.0 - initial release
// ============================================================================
package vga_timing_pkg;

  localparam int COUNT_W = 10;

  localparam int H_VISIBLE_PX = 640;
  localparam int H_FRONT_PX   = 16;
  localparam int H_SYNC_PX    = 96;
  localparam int H_BACK_PX    = 48;
  localparam int H_TOTAL_PX   = H_VISIBLE_PX + H_FRONT_PX + H_SYNC_PX + H_BACK_PX;

  localparam int V_VISIBLE_LN = 480;
  localparam int V_FRONT_LN   = 10;
  localparam int V_SYNC_LN    = 2;
  localparam int V_BACK_LN    = 33;
  localparam int V_TOTAL_LN   = V_VISIBLE_LN + V_FRONT_LN + V_SYNC_LN + V_BACK_LN;

  localparam int COLOR_W = 3;
  localparam logic [COLOR_W-1:0] BLANK_RGB = '0;

  // True when value lies in [lo, lo+len).
  function automatic logic in_window(input int value, input int lo, input int len);
    return (value >= lo) && (value < lo + len);
  endfunction

endpackage
`default_nettype wire

// File: rtl/vga_pixel_tick.sv
`default_nettype none
// ============================================================================
// Module   : vga_pixel_tick
// Purpose  : Divides the system clock into a one-clk pixel enable that fires
//            once every CLK_DIV clocks (continuously when CLK_DIV is 1).
// Revision : 1.0 - initial release
// ============================================================================
module vga_pixel_tick #(
  parameter int CLK_DIV = 2
) (
  input  logic clk,
  input  logic rst_n,
  output logic pixel_tick
);

  localparam logic [3:0] DIV_LAST = 4'(CLK_DIV - 1);

  logic [3:0] div_cnt;

  // Free-running 0..CLK_DIV-1 phase counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_cnt <= '0;
    end else if (div_cnt == DIV_LAST) begin
      div_cnt <= '0;
    end else begin
      div_cnt <= div_cnt + 4'd1;
    end
  end

  // Gating with rst_n keeps the tick low in reset even when CLK_DIV is 1,
  // where the last phase is also the reset phase.
  assign pixel_tick = rst_n & (div_cnt == DIV_LAST);

endmodule
`default_nettype wire

// File: rtl/vga_scan_generator.sv
`default_nettype none
// ============================================================================
// Module   : vga_scan_generator
// Purpose  : VGA scan counters, sync decode and registered colour/sync output
//            stage. Colour and sync leave one pixel period after row/col.
// Revision : 1.0 - initial release
// ============================================================================
module vga_scan_generator
  import vga_timing_pkg::*;
#(
  parameter int CLK_DIV   = 2,
  parameter int H_VISIBLE = H_VISIBLE_PX,
  parameter int H_FRONT   = H_FRONT_PX,
  parameter int H_SYNC    = H_SYNC_PX,
  parameter int H_BACK    = H_BACK_PX,
  parameter int V_VISIBLE = V_VISIBLE_LN,
  parameter int V_FRONT   = V_FRONT_LN,
  parameter int V_SYNC    = V_SYNC_LN,
  parameter int V_BACK    = V_BACK_LN
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [COLOR_W-1:0] rgb_in,
  output logic [COUNT_W-1:0] row,
  output logic [COUNT_W-1:0] col,
  output logic               visible,
  output logic               pixel_tick,
  output logic               frame_start,
  output logic               vga_hsync,
  output logic               vga_vsync,
  output logic [COLOR_W-1:0] vga_rgb
);

  localparam int H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

  localparam logic [COUNT_W-1:0] H_LAST = COUNT_W'(H_TOTAL - 1);
  localparam logic [COUNT_W-1:0] V_LAST = COUNT_W'(V_TOTAL - 1);
  localparam logic [COUNT_W-1:0] H_VIS  = COUNT_W'(H_VISIBLE);
  localparam logic [COUNT_W-1:0] V_VIS  = COUNT_W'(V_VISIBLE);

  logic [COUNT_W-1:0] h_count;
  logic [COUNT_W-1:0] v_count;
  logic               line_end;
  logic               frame_end;
  logic               hsync_n;
  logic               vsync_n;

  vga_pixel_tick #(
    .CLK_DIV (CLK_DIV)
  ) u_pixel_tick (
    .clk        (clk),
    .rst_n      (rst_n),
    .pixel_tick (pixel_tick)
  );

  assign line_end  = (h_count == H_LAST);
  assign frame_end = line_end && (v_count == V_LAST);

  // Horizontal/vertical scan position, advancing one pixel per tick.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      h_count <= '0;
      v_count <= '0;
    end else if (pixel_tick) begin
      if (line_end) begin
        h_count <= '0;
        v_count <= (v_count == V_LAST) ? '0 : v_count + 1'b1;
      end else begin
        h_count <= h_count + 1'b1;
      end
    end
  end

  assign row         = v_count;
  assign col         = h_count;
  assign visible     = (h_count < H_VIS) && (v_count < V_VIS);
  assign frame_start = pixel_tick & frame_end;

  // Sync pulses decoded from the position currently on row/col.
  assign hsync_n = ~in_window(int'(h_count), H_VISIBLE + H_FRONT, H_SYNC);
  assign vsync_n = ~in_window(int'(v_count), V_VISIBLE + V_FRONT, V_SYNC);

  // Connector register: sync and blanked colour for the current pixel.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vga_hsync <= 1'b1;
      vga_vsync <= 1'b1;
      vga_rgb   <= BLANK_RGB;
    end else if (pixel_tick) begin
      vga_hsync <= hsync_n;
      vga_vsync <= vsync_n;
      vga_rgb   <= visible ? rgb_in : BLANK_RGB;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_vga_scan_generator.sv
`default_nettype none
// ============================================================================
// Module   : tb_vga_scan_generator
// Purpose  : Scoreboard bench for vga_scan_generator. Three instances: the
//            default 640x480 timing at CLK_DIV=2, and two shrunken timings at
//            CLK_DIV=1 and CLK_DIV=3 so whole frames fit in a short run.
// Revision : 1.0 - initial release
// ============================================================================
module tb_vga_scan_generator;

  typedef struct {
    int tick; int fs; int vis; int hs; int vs; int row; int col; int rgb;
  } exp_t;

  // Per-instance timing: index 0 = default, 1 = small/div1, 2 = small/div3.
  int P_D  [3] = '{2, 1, 3};
  int P_HV [3] = '{640, 20, 8};
  int P_HF [3] = '{16, 3, 2};
  int P_HS [3] = '{96, 4, 3};
  int P_HB [3] = '{48, 5, 2};
  int P_VV [3] = '{480, 12, 5};
  int P_VF [3] = '{10, 2, 1};
  int P_VS [3] = '{2, 2, 2};
  int P_VB [3] = '{33, 3, 1};

  logic       clk = 1'b0;
  logic [2:0] rst_v = 3'b111;
  logic [2:0] rgb_in = 3'b000;

  logic [9:0] row_o [3];
  logic [9:0] col_o [3];
  logic       vis_o [3];
  logic       tick_o[3];
  logic       fs_o  [3];
  logic       hs_o  [3];
  logic       vs_o  [3];
  logic [2:0] rgb_o [3];

  int   n_chk  = 0;
  int   n_fail = 0;
  int   sel    = 0;
  int   cyc    = 0;
  int   last_pos = -1;
  int   last_rgb = 0;
  bit   in_rst = 1'b1;
  exp_t q[$];

  always #5 clk = ~clk;

  vga_scan_generator #(
    .CLK_DIV(2), .H_VISIBLE(640), .H_FRONT(16), .H_SYNC(96), .H_BACK(48),
    .V_VISIBLE(480), .V_FRONT(10), .V_SYNC(2), .V_BACK(33)
  ) u_a (
    .clk(clk), .rst_n(rst_v[0]), .rgb_in(rgb_in), .row(row_o[0]), .col(col_o[0]),
    .visible(vis_o[0]), .pixel_tick(tick_o[0]), .frame_start(fs_o[0]),
    .vga_hsync(hs_o[0]), .vga_vsync(vs_o[0]), .vga_rgb(rgb_o[0])
  );

  vga_scan_generator #(
    .CLK_DIV(1), .H_VISIBLE(20), .H_FRONT(3), .H_SYNC(4), .H_BACK(5),
    .V_VISIBLE(12), .V_FRONT(2), .V_SYNC(2), .V_BACK(3)
  ) u_b (
    .clk(clk), .rst_n(rst_v[1]), .rgb_in(rgb_in), .row(row_o[1]), .col(col_o[1]),
    .visible(vis_o[1]), .pixel_tick(tick_o[1]), .frame_start(fs_o[1]),
    .vga_hsync(hs_o[1]), .vga_vsync(vs_o[1]), .vga_rgb(rgb_o[1])
  );

  vga_scan_generator #(
    .CLK_DIV(3), .H_VISIBLE(8), .H_FRONT(2), .H_SYNC(3), .H_BACK(2),
    .V_VISIBLE(5), .V_FRONT(1), .V_SYNC(2), .V_BACK(1)
  ) u_c (
    .clk(clk), .rst_n(rst_v[2]), .rgb_in(rgb_in), .row(row_o[2]), .col(col_o[2]),
    .visible(vis_o[2]), .pixel_tick(tick_o[2]), .frame_start(fs_o[2]),
    .vga_hsync(hs_o[2]), .vga_vsync(vs_o[2]), .vga_rgb(rgb_o[2])
  );

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      if (n_fail <= 30)
        $display("FAIL %s: got %0d expected %0d (inst %0d cycle %0d t=%0t)",
                 name, act, exp, sel, cyc, $time);
    end
  endtask

  // Reference model: the scan position is simply the number of ticks that
  // have happened so far, modulo the frame size; the connector shows the
  // pixel sampled at the previous tick.
  task automatic push_cycle();
    int d, ht, vt, ft, done, pos, pc, pr, hsl, vsl;
    exp_t e;
    d    = P_D[sel];
    ht   = P_HV[sel] + P_HF[sel] + P_HS[sel] + P_HB[sel];
    vt   = P_VV[sel] + P_VF[sel] + P_VS[sel] + P_VB[sel];
    ft   = ht * vt;
    done = cyc / d;
    pos  = done % ft;
    e.row  = pos / ht;
    e.col  = pos % ht;
    e.vis  = (e.col < P_HV[sel] && e.row < P_VV[sel]) ? 1 : 0;
    e.tick = (cyc % d == d - 1) ? 1 : 0;
    e.fs   = (e.tick == 1 && pos == ft - 1) ? 1 : 0;
    if (last_pos < 0) begin
      e.hs = 1; e.vs = 1; e.rgb = 0;
    end else begin
      pc  = last_pos % ht;
      pr  = last_pos / ht;
      hsl = P_HV[sel] + P_HF[sel];
      vsl = P_VV[sel] + P_VF[sel];
      e.hs  = (pc >= hsl && pc < hsl + P_HS[sel]) ? 0 : 1;
      e.vs  = (pr >= vsl && pr < vsl + P_VS[sel]) ? 0 : 1;
      e.rgb = (pc < P_HV[sel] && pr < P_VV[sel]) ? last_rgb : 0;
    end
    q.push_back(e);
    if (e.tick == 1) begin
      last_pos = pos;
      last_rgb = int'(rgb_in);
    end
  endtask

  task automatic release_reset();
    @(posedge clk);
    #1;
    rst_v[sel] = 1'b1;
    in_rst     = 1'b0;
    cyc        = 0;
    last_pos   = -1;
    rgb_in     = 3'($urandom);
    push_cycle();
  endtask

  task automatic run(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
      cyc++;
      rgb_in = 3'($urandom);
      push_cycle();
    end
  endtask

  // Asynchronous reset assertion away from any clock edge.
  task automatic assert_reset();
    @(negedge clk);
    #2;
    rst_v[sel] = 1'b0;
    in_rst     = 1'b1;
    #1;
    chk("async_rst_row", int'(row_o[sel]), 0);
    chk("async_rst_col", int'(col_o[sel]), 0);
    chk("async_rst_tick", int'(tick_o[sel]), 0);
    chk("async_rst_hsync", int'(hs_o[sel]), 1);
    chk("async_rst_vsync", int'(vs_o[sel]), 1);
    chk("async_rst_rgb", int'(rgb_o[sel]), 0);
    chk("queue_at_reset", q.size(), 0);
    q.delete();
  endtask

  // Monitor: reset values while held, otherwise pop and compare each cycle.
  always @(negedge clk) begin
    exp_t e;
    if (in_rst) begin
      chk("rst_row", int'(row_o[sel]), 0);
      chk("rst_col", int'(col_o[sel]), 0);
      chk("rst_tick", int'(tick_o[sel]), 0);
      chk("rst_frame_start", int'(fs_o[sel]), 0);
      chk("rst_hsync", int'(hs_o[sel]), 1);
      chk("rst_vsync", int'(vs_o[sel]), 1);
      chk("rst_rgb", int'(rgb_o[sel]), 0);
    end else if (q.size() == 0) begin
      chk("queue_size", q.size(), 1);
    end else begin
      e = q.pop_front();
      chk("pixel_tick", int'(tick_o[sel]), e.tick);
      chk("frame_start", int'(fs_o[sel]), e.fs);
      chk("row", int'(row_o[sel]), e.row);
      chk("col", int'(col_o[sel]), e.col);
      chk("visible", int'(vis_o[sel]), e.vis);
      chk("vga_hsync", int'(hs_o[sel]), e.hs);
      chk("vga_vsync", int'(vs_o[sel]), e.vs);
      chk("vga_rgb", int'(rgb_o[sel]), e.rgb);
    end
  end

  initial begin
    #1;
    rst_v = 3'b000;

    // Default timing: reset, first tick, one full line plus the wrap.
    sel = 0;
    repeat (5) @(posedge clk);
    release_reset();
    run(2000);
    assert_reset();

    // CLK_DIV=1 small timing: frame wraps, mid-frame reset, restart.
    sel = 1;
    repeat (5) @(posedge clk);
    release_reset();
    run(1500);
    assert_reset();
    repeat (3) @(posedge clk);
    release_reset();
    run($urandom_range(300, 560));
    assert_reset();
    repeat (4) @(posedge clk);
    release_reset();
    run(1300);
    assert_reset();

    // CLK_DIV=3 small timing: divider phase and several frames.
    sel = 2;
    repeat (5) @(posedge clk);
    release_reset();
    run(1000);
    assert_reset();

    @(posedge clk);
    #1;
    chk("queue_drained", q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
